// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register addresses are held at a fixed maximum width so the stage record is parameter-free.
package pipe_pkg;

    localparam int unsigned REG_AW_MAX = 8;
    localparam int unsigned FWD_RF     = 0;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        reg_addr_t rs1;
        reg_addr_t rs2;
        logic      regwrite;
        logic      load;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{
        valid:    1'b0,
        rd:       '0,
        rs1:      '0,
        rs2:      '0,
        regwrite: 1'b0,
        load:     1'b0
    };

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline control: load-use stall, E-stage forwarding selects, redirect flush.
// Keeps a shadow record of every post-decode stage; S[0] is E, S[POST_DEPTH-1] is W.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned POST_DEPTH = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned FW         = 3,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid_i,
    input  logic [REG_AW-1:0]     d_rs1_i,
    input  logic [REG_AW-1:0]     d_rs2_i,
    input  logic                  d_use_rs1_i,
    input  logic                  d_use_rs2_i,
    input  logic [REG_AW-1:0]     d_rd_i,
    input  logic                  d_regwrite_i,
    input  logic                  d_load_i,
    input  logic                  e_redirect_i,
    output logic                  stall_f_o,
    output logic                  stall_d_o,
    output logic                  flush_d_o,
    output logic                  flush_e_o,
    output logic [FW-1:0]         fwd_a_o,
    output logic [FW-1:0]         fwd_b_o,
    output logic [POST_DEPTH-1:0] stage_valid_o,
    output logic [CNT_W-1:0]      stall_count_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    stage_t    s_q [POST_DEPTH];
    stage_t    s_d [POST_DEPTH];
    reg_addr_t rs1_w, rs2_w, rd_w;
    logic      redirect, lu, stall, flush_e;
    logic [FW-1:0] fwd_a, fwd_b;

    assign rs1_w    = REG_AW_MAX'(d_rs1_i);
    assign rs2_w    = REG_AW_MAX'(d_rs2_i);
    assign rd_w     = REG_AW_MAX'(d_rd_i);
    assign redirect = e_redirect_i & s_q[0].valid;

    // A load at S[j] reaches S[j+1] when D enters E; stall while that is short of LOAD_READY.
    always_comb begin
        lu = 1'b0;
        for (int unsigned j = 0; j < POST_DEPTH; j++) begin
            if ((j + 1 < LOAD_READY) && s_q[j].valid && s_q[j].load && s_q[j].regwrite &&
                (s_q[j].rd != '0) &&
                ((d_use_rs1_i && (s_q[j].rd == rs1_w)) ||
                 (d_use_rs2_i && (s_q[j].rd == rs2_w)))) begin
                lu = 1'b1;
            end
        end
        lu = lu & d_valid_i;
    end

    assign stall   = lu & ~redirect;
    assign flush_e = stall | redirect;

    // Scan oldest to youngest so the youngest matching producer overwrites the select.
    always_comb begin
        fwd_a = FW'(FWD_RF);
        fwd_b = FW'(FWD_RF);
        for (int unsigned k = POST_DEPTH - 1; k >= 1; k--) begin
            if (s_q[k].valid && s_q[k].regwrite && (s_q[k].rd != '0) &&
                (!s_q[k].load || (k >= LOAD_READY))) begin
                if (s_q[k].rd == s_q[0].rs1) fwd_a = FW'(k);
                if (s_q[k].rd == s_q[0].rs2) fwd_b = FW'(k);
            end
        end
        if (!s_q[0].valid) begin
            fwd_a = FW'(FWD_RF);
            fwd_b = FW'(FWD_RF);
        end
    end

    always_comb begin
        for (int unsigned k = 1; k < POST_DEPTH; k++) begin
            s_d[k] = s_q[k-1];
        end
        s_d[0] = STAGE_BUBBLE;
        if (!flush_e && d_valid_i) begin
            s_d[0].valid    = 1'b1;
            s_d[0].rd       = rd_w;
            s_d[0].rs1      = rs1_w;
            s_d[0].rs2      = rs2_w;
            s_d[0].regwrite = d_regwrite_i & (rd_w != '0);
            s_d[0].load     = d_load_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < POST_DEPTH; k++) begin
                s_q[k] <= STAGE_BUBBLE;
            end
        end else begin
            for (int unsigned k = 0; k < POST_DEPTH; k++) begin
                s_q[k] <= s_d[k];
            end
        end
    end

    always_comb begin
        stage_valid_o = '0;
        for (int unsigned k = 0; k < POST_DEPTH; k++) begin
            stage_valid_o[k] = s_q[k].valid;
        end
    end

    // Inputs are live during reset, so the combinational controls are masked explicitly.
    assign stall_f_o = stall & ~rst;
    assign stall_d_o = stall & ~rst;
    assign flush_d_o = redirect & ~rst;
    assign flush_e_o = flush_e & ~rst;
    assign fwd_a_o   = rst ? FW'(FWD_RF) : fwd_a;
    assign fwd_b_o   = rst ? FW'(FWD_RF) : fwd_b;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (stall),
        .count_o(stall_count_o)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (redirect),
        .count_o(flush_count_o)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control block for the pipelined RV32 core.
- Adds what the current pipeline lacks: load-use stalls, operand forwarding selects, and branch/jump flush.
- Tracks a shadow copy of every post-decode stage (valid, rd, regwrite, load, rs1/rs2 for the execute stage).
- Drives the F/D stall enables, the D/E flush controls and the E-stage operand mux selects. Post-decode depth and load-data readiness are configurable.

Parameters:
- REG_AW, 5: register-address width; x0 never forwards or stalls.
- POST_DEPTH, 3: stages after D. S[0]=E, S[POST_DEPTH-1]=W. Range 2..8.
- LOAD_READY, 2: first S index whose load result can be forwarded. Range 1..POST_DEPTH-1.
- FW, 3: forward-select width; must satisfy 2^FW > POST_DEPTH-1.
- CNT_W, 32: performance-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- d_valid_i  in  1  D holds a real instruction
- d_rs1_i  in  REG_AW  D source 1
- d_rs2_i  in  REG_AW  D source 2
- d_use_rs1_i  in  1  D reads rs1
- d_use_rs2_i  in  1  D reads rs2
- d_rd_i  in  REG_AW  D destination
- d_regwrite_i  in  1  D writes rd
- d_load_i  in  1  D is a load
- e_redirect_i  in  1  branch taken / jump resolved in E this cycle
- stall_f_o  out  1  hold PC register
- stall_d_o  out  1  hold F/D register
- flush_d_o  out  1  clear F/D register to bubble
- flush_e_o  out  1  load bubble into D/E register
- fwd_a_o  out  FW  E operand A source: 0 = register file, k = stage S[k] result
- fwd_b_o  out  FW  E operand B source, same encoding
- stage_valid_o  out  POST_DEPTH  valid bit per S stage
- stall_count_o  out  CNT_W  cycles with a load-use stall
- flush_count_o  out  CNT_W  accepted redirects

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All S entries invalid; both counters 0.
  - All outputs 0. Outputs stay 0 while rst is high, whatever the inputs.
- Timing: all outputs are combinational from current state and D inputs. Zero-cycle latency to the pipeline registers, which act on the next edge.
- redirect = e_redirect_i & S[0].valid. An unqualified e_redirect_i is ignored.
- Load-use hazard (lu):
  - Condition: d_valid_i, and some j with S[j].valid & S[j].load & S[j].regwrite & S[j].rd!=0 & j+1<LOAD_READY.
  - S[j].rd must match d_rs1_i with d_use_rs1_i set, or d_rs2_i with d_use_rs2_i set.
  - With the defaults this is only j=0: one stall cycle.
- Output equations:
  - stall = lu & !redirect; redirect has priority because the D instruction is discarded.
  - stall_f_o = stall_d_o = stall.
  - flush_d_o = redirect.
  - flush_e_o = stall | redirect.
- Shift on every edge; post-decode stages never stall:
  - S[k] <= S[k-1] for k >= 1.
  - S[0] <= bubble if flush_e_o or !d_valid_i; otherwise D fields, with regwrite forced 0 when d_rd_i==0.
- Forwarding for E operand A (B identical, using S[0].rs2):
  - Applies only if S[0].valid.
  - Select the smallest k in 1..POST_DEPTH-1 with S[k].valid & S[k].regwrite & S[k].rd==S[0].rs1 & S[k].rd!=0 & (!S[k].load | k>=LOAD_READY).
  - No match gives 0. The youngest producer wins.
- Retirement from W must be visible to the D read through the register file's same-cycle write-through. This block never forwards retired results.
- Counters:
  - stall_count_o increments on each edge where stall=1.
  - flush_count_o increments on each edge where redirect=1.
  - Both saturate at all-ones.
- Stall and redirect in the same cycle: redirect only, counted once in flush_count_o.

Decomposition:
- Package pipe_pkg:
  - stage_t struct {valid, rd, rs1, rs2, regwrite, load}.
  - FWD_RF = 0 constant.
  - Bubble constant STAGE_BUBBLE.
- Sub-module sat_counter #(CNT_W): async reset, increment enable, saturating. Instantiated twice.

Test Plan:
- Reset asserted mid-run with S fully valid -> stage_valid_o=0, fwd_a_o/fwd_b_o=0, counters 0 immediately, without waiting for a clock edge.
- D reads x5 via add x6,x5,x5 while lw x5 sits in S[0] -> stall_f_o=stall_d_o=flush_e_o=1 for exactly 1 cycle. Then fwd_a_o=fwd_b_o=2; stall_count_o=1.
- addi x1 in S[1] and addi x1 in S[2], E reads x1 -> fwd_a_o=1 (youngest producer wins). E reads x0 with producer rd=0 -> fwd_a_o=0.
- Load-use condition and e_redirect_i with S[0] valid in the same cycle -> stall=0, flush_d_o=flush_e_o=1, flush_count_o=1, stall_count_o unchanged.
- e_redirect_i with S[0] invalid -> all flush/stall outputs 0, counters unchanged.
- POST_DEPTH=4, LOAD_READY=3: load in S[1] matching the D source -> stall; load in S[2] -> no stall; E forwarding from S[3] -> fwd=3. Also force stall_count_o to all-ones and check it holds.
